br_fifo_shared_read_port_arbiter: RTL and testbench

BR_FIFO_SHARED_READ_PORT_ARBITER -- requirements
Module: br_fifo_shared_read_port_arbiter

---
 rtl/br_math.sv | 16 +
 rtl/br_fifo_shared_read_port_arbiter_wrr.sv | 96 +++++++++
 rtl/br_fifo_shared_read_port_arbiter.sv | 89 ++++++++
 tb/tb_br_fifo_shared_read_port_arbiter.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/br_math.sv
// Small math helpers shared across the br_* blocks.
//
// clamped_clog2(value): ceil(log2(value)), but never less than 1, so a
// width derived from it is always legal even when value is 0, 1 or 2.
package br_math;

    function automatic int clamped_clog2(input int value);
        int result;
        result = 1;
        if (value > 2) begin
            result = $clog2(value);
        end
        return result;
    endfunction

endpackage

// File: rtl/br_fifo_shared_read_port_arbiter_wrr.sv
// Weighted round-robin arbiter for a single FIFO read port.
//
// The arbiter remembers the last granted FIFO (ptr) and how many grants
// that FIFO has received in its current burst (cnt). A FIFO keeps the
// grant until it has used its burst weight; after that the search moves
// on round-robin starting just past ptr, with ptr itself checked last.
//
// Ports:
//   clk                    - clock
//   rst                    - synchronous reset, active low
//   request[NumFifos]      - requests already masked by lower-index ports
//   weight[NumFifos]       - per-FIFO burst weight (0 behaves as 1)
//   enable_priority_update - commit ptr/cnt for this cycle's grant
//   grant[NumFifos]        - onehot0 grant, combinational from inputs/state
module br_fifo_shared_read_port_arbiter_wrr #(
    parameter int NumFifos  = 2,
    parameter int MaxWeight = 1
) (
    input  logic                                              clk,
    input  logic                                              rst,
    input  logic [NumFifos-1:0]                               request,
    input  logic [NumFifos-1:0][br_math::clamped_clog2(MaxWeight+1)-1:0] weight,
    input  logic                                              enable_priority_update,
    output logic [NumFifos-1:0]                               grant
);

    localparam int FifoIdWidth = br_math::clamped_clog2(NumFifos);
    localparam int WeightWidth = br_math::clamped_clog2(MaxWeight + 1);
    localparam int SumWidth    = FifoIdWidth + 1;

    logic [FifoIdWidth-1:0]  ptr;
    logic [WeightWidth-1:0]  cnt;

    logic [WeightWidth-1:0]  ptr_weight;
    logic                    hold;
    logic [FifoIdWidth-1:0]  start_idx;
    logic [2*NumFifos-1:0]   req_dbl;
    logic [2*NumFifos-1:0]   req_shift;
    logic [NumFifos-1:0]     req_rot;
    logic [FifoIdWidth-1:0]  rot_idx;
    logic [SumWidth-1:0]     idx_sum;
    logic [FifoIdWidth-1:0]  search_idx;
    logic                    grant_valid;
    logic [FifoIdWidth-1:0]  grant_idx;

    always_comb begin
        // A zero weight still earns one grant per visit.
        ptr_weight = (weight[ptr] == '0) ? WeightWidth'(1) : weight[ptr];
        hold       = request[ptr] && (cnt < ptr_weight);

        // Rotate the request vector so bit 0 is the FIFO just after ptr;
        // the doubled copy makes the rotation a plain shift even when
        // NumFifos is not a power of two.
        start_idx = (ptr == FifoIdWidth'(NumFifos - 1)) ? '0 : ptr + FifoIdWidth'(1);
        req_dbl   = {request, request};
        req_shift = req_dbl >> start_idx;
        req_rot   = req_shift[NumFifos-1:0];

        rot_idx = '0;
        for (int i = NumFifos - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                rot_idx = FifoIdWidth'(i);
            end
        end

        // Undo the rotation, wrapping modulo NumFifos.
        idx_sum = {1'b0, start_idx} + {1'b0, rot_idx};
        if (idx_sum >= SumWidth'(NumFifos)) begin
            idx_sum = idx_sum - SumWidth'(NumFifos);
        end
        search_idx = idx_sum[FifoIdWidth-1:0];

        grant_valid = rst && (|request);
        grant_idx   = hold ? ptr : search_idx;
        grant       = grant_valid ? (NumFifos'(1) << grant_idx) : '0;
    end

    // After reset the burst is marked exhausted on the last FIFO, so the
    // first search starts at FIFO 0.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ptr <= FifoIdWidth'(NumFifos - 1);
            cnt <= WeightWidth'(MaxWeight);
        end else if (enable_priority_update && grant_valid) begin
            if (hold) begin
                if (cnt != WeightWidth'(MaxWeight)) begin
                    cnt <= cnt + WeightWidth'(1);
                end
            end else begin
                ptr <= search_idx;
                cnt <= WeightWidth'(1);
            end
        end
    end

endmodule

// File: rtl/br_fifo_shared_read_port_arbiter.sv
// Read-port arbiter for a set of logical FIFOs sharing NumReadPorts
// physical read ports. Each port runs its own weighted round-robin
// arbiter; a FIFO granted by a lower-index port is hidden from every
// higher-index port in the same cycle, so no FIFO is read twice.
//
// Ports:
//   clk                                   - clock
//   rst                                   - synchronous reset, active low
//   arb_request[NumReadPorts][NumFifos]   - per-port FIFO requests
//   arb_grant[NumReadPorts][NumFifos]     - per-port onehot0 grants
//   arb_enable_priority_update[NumReadPorts] - commit that port's state
//   weight[NumFifos][WeightWidth]         - burst weight, shared by ports
module br_fifo_shared_read_port_arbiter #(
    parameter int NumFifos     = 2,
    parameter int NumReadPorts = 1,
    parameter int MaxWeight    = 1
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic [NumReadPorts-1:0][NumFifos-1:0]       arb_request,
    output logic [NumReadPorts-1:0][NumFifos-1:0]       arb_grant,
    input  logic [NumReadPorts-1:0]                     arb_enable_priority_update,
    input  logic [NumFifos-1:0][br_math::clamped_clog2(MaxWeight+1)-1:0] weight
);

    localparam int WeightWidth = br_math::clamped_clog2(MaxWeight + 1);

    // Elaboration-time parameter checks.
    if (NumFifos < 2) begin : g_bad_num_fifos
        $error("NumFifos must be at least 2");
    end
    if ((NumReadPorts < 1) || ((NumReadPorts & (NumReadPorts - 1)) != 0)) begin : g_bad_num_ports
        $error("NumReadPorts must be a power of two and at least 1");
    end
    if (MaxWeight < 1) begin : g_bad_max_weight
        $error("MaxWeight must be at least 1");
    end

    // Each port sees the union of grants from all lower ports through a
    // per-port chain of separate signals.
    for (genvar p = 0; p < NumReadPorts; p++) begin : g_port
        logic [NumFifos-1:0] taken_in;
        logic [NumFifos-1:0] taken_out;
        logic [NumFifos-1:0] masked_req;
        logic [NumFifos-1:0] port_grant;

        if (p == 0) begin : g_first
            assign taken_in = '0;
        end else begin : g_rest
            assign taken_in = g_port[p-1].taken_out;
        end

        assign masked_req = arb_request[p] & ~taken_in;
        assign taken_out  = taken_in | port_grant;
        assign arb_grant[p] = port_grant;

        br_fifo_shared_read_port_arbiter_wrr #(
            .NumFifos  (NumFifos),
            .MaxWeight (MaxWeight)
        ) u_wrr (
            .clk                    (clk),
            .rst                    (rst),
            .request                (masked_req),
            .weight                 (weight),
            .enable_priority_update (arb_enable_priority_update[p]),
            .grant                  (port_grant)
        );

        a_grant_onehot0: assert property (@(posedge clk) disable iff (!rst)
            $onehot0(arb_grant[p]));
    end

    for (genvar f = 0; f < NumFifos; f++) begin : g_fifo
        logic [NumReadPorts-1:0] grant_col;

        for (genvar p = 0; p < NumReadPorts; p++) begin : g_col
            assign grant_col[p] = arb_grant[p][f];
        end

        a_column_onehot0: assert property (@(posedge clk) disable iff (!rst)
            $onehot0(grant_col));
        a_weight_range: assert property (@(posedge clk) disable iff (!rst)
            weight[f] <= WeightWidth'(MaxWeight));
    end

    a_request_known: assert property (@(posedge clk) disable iff (!rst)
        !$isunknown(arb_request));

endmodule

// File: tb/tb_br_fifo_shared_read_port_arbiter.sv
module tb_br_fifo_shared_read_port_arbiter;

  localparam int NF = 4;
  localparam int NP = 2;
  localparam int MW = 4;
  localparam int WW = 3;

  // clock / reset
  logic clk;
  logic rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [NP-1:0][NF-1:0] arb_request;
  logic [NP-1:0][NF-1:0] arb_grant;
  logic [NP-1:0]         arb_enable_priority_update;
  logic [NF-1:0][WW-1:0] weight;

  br_fifo_shared_read_port_arbiter #(
    .NumFifos     (NF),
    .NumReadPorts (NP),
    .MaxWeight    (MW)
  ) dut (
    .clk                        (clk),
    .rst                        (rst),
    .arb_request                (arb_request),
    .arb_grant                  (arb_grant),
    .arb_enable_priority_update (arb_enable_priority_update),
    .weight                     (weight)
  );

  // scoreboard: {port1 grant, port0 grant}
  logic [NP*NF-1:0] exp_q[$];
  int err_cnt;
  int chk_cnt;

  task automatic check_eq(input string tag, input logic [NP*NF-1:0] got, input logic [NP*NF-1:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic set_w(input int w0, input int w1, input int w2, input int w3);
    weight[0] = WW'(w0);
    weight[1] = WW'(w1);
    weight[2] = WW'(w2);
    weight[3] = WW'(w3);
  endtask

  // Drive one cycle of stimulus, queue its expected grant, compare on the
  // falling edge, then advance past the committing rising edge.
  task automatic step(input logic [NF-1:0] r0, input logic [NF-1:0] r1,
                      input logic [NP-1:0] upd, input logic rn,
                      input logic [NP*NF-1:0] exp, input string tag);
    logic [NP*NF-1:0] e;
    arb_request[0] = r0;
    arb_request[1] = r1;
    arb_enable_priority_update = upd;
    rst = rn;
    exp_q.push_back(exp);
    @(negedge clk);
    if (exp_q.size() == 0) begin
      err_cnt++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      e = exp_q.pop_front();
      check_eq(tag, arb_grant, e);
    end
    @(posedge clk);
    #1;
  endtask

  // Reference model for the random phase: independent per-port state.
  int m_ptr[NP];
  int m_cnt[NP];

  task automatic model(input logic [NF-1:0] r0, input logic [NF-1:0] r1,
                       input logic [NP-1:0] upd, input logic rn,
                       output logic [NP*NF-1:0] exp);
    logic [NF-1:0] req[NP];
    logic [NF-1:0] taken;
    logic [NF-1:0] mr;
    int ew;
    int g;
    int idx;
    bit h;
    req[0] = r0;
    req[1] = r1;
    taken = '0;
    exp = '0;
    for (int p = 0; p < NP; p++) begin
      if (!rn) begin
        m_ptr[p] = NF - 1;
        m_cnt[p] = MW;
      end else begin
        mr = req[p] & ~taken;
        ew = (weight[m_ptr[p]] == 0) ? 1 : int'(weight[m_ptr[p]]);
        g = -1;
        h = 1'b0;
        if (mr[m_ptr[p]] && (m_cnt[p] < ew)) begin
          g = m_ptr[p];
          h = 1'b1;
        end else begin
          for (int k = 1; k <= NF; k++) begin
            idx = (m_ptr[p] + k) % NF;
            if (g < 0 && mr[idx]) g = idx;
          end
        end
        if (g >= 0) begin
          exp[p*NF + g] = 1'b1;
          taken[g] = 1'b1;
          if (upd[p]) begin
            if (h) m_cnt[p] = m_cnt[p] + 1;
            else begin
              m_ptr[p] = g;
              m_cnt[p] = 1;
            end
          end
        end
      end
    end
  endtask

  initial begin
    logic [NF-1:0] r0;
    logic [NF-1:0] r1;
    logic [NP-1:0] upd;
    logic rn;
    logic [NP*NF-1:0] e;

    err_cnt = 0;
    chk_cnt = 0;
    rst = 1'b0;
    arb_request = '0;
    arb_enable_priority_update = '0;
    set_w(1, 1, 1, 1);
    @(posedge clk);
    #1;

    // reset forces grants to zero
    step(4'b1111, 4'b1111, 2'b11, 1'b0, 8'h00, "reset_a");
    step(4'b1111, 4'b1111, 2'b11, 1'b0, 8'h00, "reset_b");

    // plain round robin, weights 1
    step(4'b1111, 4'b0000, 2'b01, 1'b1, 8'h01, "rr_0");
    step(4'b1111, 4'b0000, 2'b01, 1'b1, 8'h02, "rr_1");
    step(4'b1111, 4'b0000, 2'b01, 1'b1, 8'h04, "rr_2");
    step(4'b1111, 4'b0000, 2'b01, 1'b1, 8'h08, "rr_3");
    step(4'b1111, 4'b0000, 2'b01, 1'b1, 8'h01, "rr_wrap");

    // weighted bursts: f0=1 f1=3 f2=2
    set_w(1, 3, 2, 1);
    step(4'b0111, 4'b0000, 2'b01, 1'b0, 8'h00, "wrr_rst");
    step(4'b0111, 4'b0000, 2'b01, 1'b1, 8'h01, "wrr_0");
    step(4'b0111, 4'b0000, 2'b01, 1'b1, 8'h02, "wrr_1a");
    step(4'b0111, 4'b0000, 2'b01, 1'b1, 8'h02, "wrr_1b");
    step(4'b0111, 4'b0000, 2'b01, 1'b1, 8'h02, "wrr_1c");
    step(4'b0111, 4'b0000, 2'b01, 1'b1, 8'h04, "wrr_2a");
    step(4'b0111, 4'b0000, 2'b01, 1'b1, 8'h04, "wrr_2b");
    step(4'b0111, 4'b0000, 2'b01, 1'b1, 8'h01, "wrr_0_again");

    // lone requester granted every cycle, then newcomer FIFO 0 wins
    set_w(1, 1, 1, 1);
    step(4'b0100, 4'b0000, 2'b01, 1'b0, 8'h00, "lone_rst");
    for (int i = 0; i < 3; i++) step(4'b0100, 4'b0000, 2'b01, 1'b1, 8'h04, "lone_f2");
    step(4'b0101, 4'b0000, 2'b01, 1'b1, 8'h01, "lone_add_f0");

    // update held low: state frozen, grant stays on FIFO 1
    for (int i = 0; i < 5; i++) step(4'b0110, 4'b0000, 2'b00, 1'b1, 8'h02, "noupd_f1");
    step(4'b0110, 4'b0000, 2'b01, 1'b1, 8'h02, "upd_commit_f1");
    step(4'b0110, 4'b0000, 2'b01, 1'b1, 8'h04, "upd_next_f2");

    // cross-port exclusion
    step(4'b0010, 4'b0010, 2'b11, 1'b1, 8'h02, "excl_same");
    step(4'b0010, 4'b1010, 2'b11, 1'b1, 8'h82, "excl_alt");

    // reset mid-burst discards burst state
    set_w(1, 3, 1, 1);
    step(4'b1111, 4'b0000, 2'b01, 1'b0, 8'h00, "mid_rst_pre");
    step(4'b1111, 4'b0000, 2'b01, 1'b1, 8'h01, "mid_f0");
    step(4'b1111, 4'b0000, 2'b01, 1'b1, 8'h02, "mid_f1a");
    step(4'b1111, 4'b0000, 2'b01, 1'b1, 8'h02, "mid_f1b");
    step(4'b1111, 4'b0000, 2'b01, 1'b0, 8'h00, "mid_rst_a");
    step(4'b1111, 4'b0000, 2'b01, 1'b0, 8'h00, "mid_rst_b");
    step(4'b1111, 4'b0000, 2'b01, 1'b1, 8'h01, "mid_after");

    // random traffic against the reference model
    model(4'b0000, 4'b0000, 2'b00, 1'b0, e);
    step(4'b0000, 4'b0000, 2'b00, 1'b0, e, "rand_rst");
    for (int n = 0; n < 400; n++) begin
      if (n % 25 == 0) begin
        set_w($urandom_range(0, MW), $urandom_range(0, MW),
              $urandom_range(0, MW), $urandom_range(0, MW));
      end
      r0 = NF'($urandom_range(0, 15));
      r1 = NF'($urandom_range(0, 15));
      upd = NP'($urandom_range(0, 3));
      rn = ($urandom_range(0, 39) != 0);
      model(r0, r1, upd, rn, e);
      step(r0, r1, upd, rn, e, "rand");
    end

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
